reorder_buffer: RTL and testbench

- Circular in-order retirement buffer sitting directly upstream of the tagged register file.
- The decoder allocates one entry per issued instruction, and the entry index is used as the rename tag.
- Execution results arrive over the CDB and are buffered per entry.
- The head entry retires in program order and drives the register file's ROB write port: enWrite/namew/dataw/tagw.

---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/rob_ptr.sv | 19 +
 rtl/reorder_buffer.sv | 176 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, the free-tag encoding and the ROB entry record used by the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_ENTRIES = 8;
    localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);
    localparam int TAG_W       = ROB_IDX_W + 1;
    localparam int regWidth    = 5;
    localparam int dataWidth   = 32;

    // MSB set marks "no producer"; the register file treats it as an architectural value.
    localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {ROB_IDX_W{1'b0}}};

    typedef struct packed {
        logic                 valid;
        logic                 ready;
        logic [regWidth-1:0]  rd;
        logic [dataWidth-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping index pointer; wraps for free because the entry count is a power of two.
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer feeding the register file's ROB write port.
// Define ROB_FWD_EN to build the combinational operand-forwarding lookup.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int ENTRIES = ROB_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = IDX_W + 1,
    localparam int REG_W   = regWidth,
    localparam int DATA_W  = dataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_en,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    input  logic [TAG_W-1:0]  fwd_tag,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(ENTRIES);
    localparam logic [TAG_W-1:0] FREE_TAG   = {1'b1, {IDX_W{1'b0}}};

    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic [IDX_W:0]     count_reg;
    logic [IDX_W:0]     count_next;
    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] valid_next;
    logic [ENTRIES-1:0] ready_reg;
    logic [ENTRIES-1:0] ready_next;
    logic [REG_W-1:0]   rd_mem   [ENTRIES];
    logic [DATA_W-1:0]  data_mem [ENTRIES];

    logic             alloc_fire;
    logic             cdb_fire;
    logic             commit_fire;
    logic [IDX_W-1:0] cdb_idx;
    rob_entry_t       head_entry;

    assign alloc_ready = (count_reg != FULL_COUNT);
    assign alloc_tag   = {1'b0, tail};
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign cdb_idx     = cdb_tag[IDX_W-1:0];

    // The slot being allocated this cycle cannot yet be a CDB target.
    assign cdb_fire = cdb_valid && !cdb_tag[TAG_W-1] && valid_reg[cdb_idx]
                      && !(alloc_fire && (cdb_idx == tail));

    always_comb begin
        head_entry       = '0;
        head_entry.valid = valid_reg[head];
        head_entry.ready = ready_reg[head];
        head_entry.rd    = rd_mem[head];
        head_entry.data  = data_mem[head];
    end

    assign commit_fire = head_entry.valid && head_entry.ready;

    rob_ptr #(.W(IDX_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (commit_fire),
        .ptr (head)
    );

    rob_ptr #(.W(IDX_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (alloc_fire),
        .ptr (tail)
    );

    // Later assignments win: retire clears a slot, allocation re-arms it.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_comb begin
                valid_next[gi] = valid_reg[gi];
                ready_next[gi] = ready_reg[gi];
                if (cdb_fire && (cdb_idx == IDX_W'(gi))) begin
                    ready_next[gi] = 1'b1;
                end
                if (commit_fire && (head == IDX_W'(gi))) begin
                    valid_next[gi] = 1'b0;
                    ready_next[gi] = 1'b0;
                end
                if (alloc_fire && (tail == IDX_W'(gi))) begin
                    valid_next[gi] = 1'b1;
                    ready_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({alloc_fire, commit_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            ready_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            ready_reg <= ready_next;
            count_reg <= count_next;
        end
    end

    // Payload storage carries no reset; valid/ready qualify every read.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail] <= alloc_rd;
        end
        if (cdb_fire) begin
            data_mem[cdb_idx] <= cdb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_en   <= 1'b0;
            commit_rd   <= '0;
            commit_data <= '0;
            commit_tag  <= FREE_TAG;
        end else if (commit_fire) begin
            commit_en   <= 1'b1;
            commit_rd   <= head_entry.rd;
            commit_data <= head_entry.data;
            commit_tag  <= {1'b0, head};
        end else begin
            commit_en   <= 1'b0;
        end
    end

`ifdef ROB_FWD_EN
    logic [IDX_W-1:0] fwd_idx;
    assign fwd_idx = fwd_tag[IDX_W-1:0];

    // A result on the CDB this cycle takes priority over the buffered copy.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (!fwd_tag[TAG_W-1] && valid_reg[fwd_idx]) begin
            if (cdb_valid && (cdb_tag == fwd_tag)) begin
                fwd_hit  = 1'b1;
                fwd_data = cdb_data;
            end else if (ready_reg[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_tag;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer; each row's expectations describe the state after its clock edge.
module tb_reorder_buffer;

`ifdef ROB_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = 4'd8;
    logic [31:0] cdb_data = '0;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [3:0]  commit_tag;
    logic [3:0]  fwd_tag = 4'd8;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .commit_en   (commit_en),
        .commit_rd   (commit_rd),
        .commit_data (commit_data),
        .commit_tag  (commit_tag),
        .fwd_tag     (fwd_tag),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic        cv;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic [3:0]  ftag;
        logic        e_rdy;
        logic [3:0]  e_atag;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [3:0]  e_ctag;
        logic        e_fhit;
        logic [31:0] e_fdata;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic r, input logic av, input logic [4:0] ard,
                        input logic cv, input logic [3:0] ctag, input logic [31:0] cdata,
                        input logic [3:0] ftag, input logic e_rdy, input logic [3:0] e_atag,
                        input logic e_en, input logic [4:0] e_rd, input logic [31:0] e_data,
                        input logic [3:0] e_ctag, input logic e_fhit, input logic [31:0] e_fdata);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
        v.ftag = ftag; v.e_rdy = e_rdy; v.e_atag = e_atag; v.e_en = e_en; v.e_rd = e_rd;
        v.e_data = e_data; v.e_ctag = e_ctag; v.e_fhit = e_fhit; v.e_fdata = e_fdata;
        vecs.push_back(v);
    endtask

    task automatic push_rst();
        push(1, 0, 0, 0, 4'd8, 0, 4'd8, 1, 0, 0, 0, 0, 4'd8, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_tag = 4'd8; cdb_data = '0;
        fwd_tag = 4'd8;
    endtask

    initial begin
        // Sequence A: single allocate, complete, retire two edges later
        push_rst();
        push(0, 1, 3, 0, 8, 0,            8, 1, 1, 0, 0, 0,            8, 0, 0);
        push(0, 0, 0, 1, 0, 32'hDEADBEEF, 8, 1, 1, 0, 0, 0,            8, 0, 0);
        push(0, 0, 0, 0, 8, 0,            8, 1, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0);
        push(0, 0, 0, 0, 8, 0,            8, 1, 1, 0, 3, 32'hDEADBEEF, 0, 0, 0);
        // Sequence B: out-of-order completion, in-order retirement
        push_rst();
        push(0, 1, 1, 0, 8, 0,     8, 1, 1, 0, 0, 0,     8, 0, 0);
        push(0, 1, 2, 0, 8, 0,     8, 1, 2, 0, 0, 0,     8, 0, 0);
        push(0, 1, 3, 0, 8, 0,     8, 1, 3, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 1, 2, 'h22,  8, 1, 3, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 1, 1, 'h11,  8, 1, 3, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 1, 0, 'h00,  8, 1, 3, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 3, 1, 1, 'h00,  0, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 3, 1, 2, 'h11,  1, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 3, 1, 3, 'h22,  2, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 3, 0, 3, 'h22,  2, 0, 0);
        // Sequence C: fill, ignored 9th alloc, commit while full, tag 0 re-granted
        push_rst();
        for (int i = 0; i < 8; i++) begin
            push(0, 1, 5'(10 + i), 0, 8, 0, 8, (i < 7), 4'((i + 1) % 8), 0, 0, 0, 8, 0, 0);
        end
        push(0, 1, 31, 0, 8, 0,     8, 0, 0, 0, 0,  0,     8, 0, 0);
        push(0, 0, 0,  1, 0, 'hA0,  8, 0, 0, 0, 0,  0,     8, 0, 0);
        push(0, 1, 25, 0, 8, 0,     8, 1, 0, 1, 10, 'hA0,  0, 0, 0);
        push(0, 1, 20, 0, 8, 0,     8, 0, 1, 0, 10, 'hA0,  0, 0, 0);
        push(0, 0, 0,  1, 1, 'hB1,  8, 0, 1, 0, 10, 'hA0,  0, 0, 0);
        push(0, 0, 0,  0, 8, 0,     8, 1, 1, 1, 11, 'hB1,  1, 0, 0);
        push(0, 0, 0,  1, 8, 'hFF,  8, 1, 1, 0, 11, 'hB1,  1, 0, 0);
        // Sequence D: CDB to the slot being allocated is dropped
        push_rst();
        push(0, 1, 5, 1, 0, 'h99,  8, 1, 1, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 1, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 1, 0, 'h66,  8, 1, 1, 0, 0, 0,     8, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 1, 1, 5, 'h66,  0, 0, 0);
        // Sequence E: forwarding lookups from buffered results
        push_rst();
        push(0, 1, 1, 0, 8, 0,     8, 1, 1, 0, 0, 0, 8, 0, 0);
        push(0, 1, 2, 0, 8, 0,     8, 1, 2, 0, 0, 0, 8, 0, 0);
        push(0, 1, 3, 0, 8, 0,     8, 1, 3, 0, 0, 0, 8, 0, 0);
        push(0, 0, 0, 1, 1, 'h55,  8, 1, 3, 0, 0, 0, 8, 0, 0);
        push(0, 0, 0, 0, 8, 0,     1, 1, 3, 0, 0, 0, 8, 1, 'h55);
        push(0, 0, 0, 0, 8, 0,     0, 1, 3, 0, 0, 0, 8, 0, 0);
        push(0, 0, 0, 0, 8, 0,     8, 1, 3, 0, 0, 0, 8, 0, 0);

        #2;
        for (int r = 0; r < vecs.size(); r++) begin
            vec_t v;
            v = vecs[r];
            if (v.rst) begin
                idle_inputs();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                alloc_valid = v.av; alloc_rd = v.ard;
                cdb_valid = v.cv; cdb_tag = v.ctag; cdb_data = v.cdata;
                fwd_tag = v.ftag;
                tick();
            end
            chk("alloc_ready", r, 32'(alloc_ready), 32'(v.e_rdy));
            chk("alloc_tag",   r, 32'(alloc_tag),   32'(v.e_atag));
            chk("commit_en",   r, 32'(commit_en),   32'(v.e_en));
            chk("commit_rd",   r, 32'(commit_rd),   32'(v.e_rd));
            chk("commit_data", r, commit_data,      v.e_data);
            chk("commit_tag",  r, 32'(commit_tag),  32'(v.e_ctag));
            chk("fwd_hit",     r, 32'(fwd_hit),     32'(FWD_ON ? v.e_fhit : 1'b0));
            chk("fwd_data",    r, fwd_data,         FWD_ON ? v.e_fdata : 32'h0);
            $display("row %0d: rst=%0b av=%0b cdb=%0b/%0d en=%0b rd=%0d data=0x%0h tag=%0d atag=%0d rdy=%0b",
                     r, v.rst, v.av, v.cv, v.ctag, commit_en, commit_rd, commit_data, commit_tag, alloc_tag, alloc_ready);
        end

        // Same-cycle CDB bypass to a valid, not-yet-ready entry (tag 2)
        idle_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h77; fwd_tag = 4'd2;
        #1;
        chk("fwd_bypass_hit",  100, 32'(fwd_hit), 32'(FWD_ON));
        chk("fwd_bypass_data", 100, fwd_data, FWD_ON ? 32'h77 : 32'h0);
        fwd_tag = 4'd3;
        #1;
        chk("fwd_other_hit", 101, 32'(fwd_hit), 32'h0);
        fwd_tag = 4'd8;
        #1;
        chk("fwd_free_hit", 102, 32'(fwd_hit), 32'h0);
        $display("bypass: fwd_tag=2 cdb_tag=2 data=0x77 checked");
        tick();
        idle_inputs();

        // Asynchronous reset mid-cycle discards the pending entries
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tag",   103, 32'(alloc_tag),   32'h0);
        chk("async_rst_ready", 103, 32'(alloc_ready), 32'h1);
        tick();
        rst = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h12;
        tick();
        idle_inputs();
        tick();
        chk("post_rst_no_commit", 104, 32'(commit_en), 32'h0);
        $display("async reset: alloc_tag=%0d commit_en=%0b", alloc_tag, commit_en);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
